// File: rtl/unidade_controle_quiz.sv
// Quiz control unit: Moore FSM with question, attempt, timeout and score registers.
// Optional macro BONUS_RAPIDO_EN: fast correct answers add 2 points instead of 1.
module unidade_controle_quiz #(
    parameter int N_PERGUNTAS    = 8,
    parameter int NB             = 4,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int MAX_TENTATIVAS = 2,
    localparam int AW  = (N_PERGUNTAS > 2) ? $clog2(N_PERGUNTAS) : 1,
    localparam int SW  = $clog2(2 * N_PERGUNTAS + 1),
    localparam int TW  = $clog2(TIMEOUT_CICLOS),
    localparam int TAW = $clog2(MAX_TENTATIVAS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iniciar,
    input  logic [NB-1:0] jogada,
    input  logic [NB-1:0] resposta_certa,
    output logic [AW-1:0] endereco,
    output logic [SW-1:0] score,
    output logic          acertou,
    output logic          errou,
    output logic          timeout,
    output logic          pronto,
    output logic [3:0]    db_estado
);

    typedef enum logic [3:0] {
        ST_INICIAL  = 4'h0,
        ST_PREPARA  = 4'h1,
        ST_AGUARDA  = 4'h5,
        ST_REGISTRA = 4'h6,
        ST_COMPARA  = 4'h7,
        ST_ACERTOU  = 4'h8,
        ST_ERROU    = 4'h9,
        ST_PROXIMA  = 4'hA,
        ST_FIM      = 4'hB,
        ST_SOLTA    = 4'hC,
        ST_TIMEOUT  = 4'hD
    } estado_t;

    localparam int SMAX = 2 * N_PERGUNTAS;

    estado_t       state_q, state_d;
    logic [AW-1:0] endereco_q, endereco_d;
    logic [SW-1:0] score_q, score_d;
    logic [TAW-1:0] tentativas_q, tentativas_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [NB-1:0] jogada_reg_q, jogada_reg_d;
    logic          avanca_q, avanca_d;
    logic [SW:0]   soma;
    logic [TAW-1:0] tent_inc;
    logic [1:0]    incremento;

`ifdef BONUS_RAPIDO_EN
    logic rapido_q, rapido_d;
    assign incremento = rapido_q ? 2'd2 : 2'd1;
`else
    assign incremento = 2'd1;
`endif

    // Score sum is one bit wider so saturation can be detected.
    assign soma     = {1'b0, score_q} + (SW+1)'(incremento);
    assign tent_inc = tentativas_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        endereco_d   = endereco_q;
        score_d      = score_q;
        tentativas_d = tentativas_q;
        timer_d      = '0;
        jogada_reg_d = jogada_reg_q;
        avanca_d     = avanca_q;
`ifdef BONUS_RAPIDO_EN
        rapido_d     = rapido_q;
`endif
        case (state_q)
            ST_INICIAL, ST_FIM, ST_TIMEOUT: begin
                if (iniciar) begin
                    state_d      = ST_PREPARA;
                    endereco_d   = '0;
                    score_d      = '0;
                    tentativas_d = '0;
                end
            end
            ST_PREPARA: begin
                endereco_d   = '0;
                score_d      = '0;
                tentativas_d = '0;
                state_d      = ST_AGUARDA;
            end
            ST_AGUARDA: begin
                if (jogada != '0) begin
                    state_d = ST_REGISTRA;
`ifdef BONUS_RAPIDO_EN
                    rapido_d = (timer_q < TW'(TIMEOUT_CICLOS / 2));
`endif
                end else if (timer_q == TW'(TIMEOUT_CICLOS - 1)) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_REGISTRA: begin
                jogada_reg_d = jogada;
                state_d      = ST_COMPARA;
            end
            ST_COMPARA: begin
                if (jogada_reg_q == resposta_certa)
                    state_d = ST_ACERTOU;
                else
                    state_d = ST_ERROU;
            end
            ST_ACERTOU: begin
                if (soma > (SW+1)'(SMAX))
                    score_d = SW'(SMAX);
                else
                    score_d = soma[SW-1:0];
                avanca_d = 1'b1;
                state_d  = ST_SOLTA;
            end
            ST_ERROU: begin
                tentativas_d = tent_inc;
                avanca_d     = (tent_inc == TAW'(MAX_TENTATIVAS));
                state_d      = ST_SOLTA;
            end
            ST_SOLTA: begin
                if (jogada == '0)
                    state_d = avanca_q ? ST_PROXIMA : ST_AGUARDA;
            end
            ST_PROXIMA: begin
                if (endereco_q == AW'(N_PERGUNTAS - 1)) begin
                    state_d = ST_FIM;
                end else begin
                    endereco_d   = endereco_q + 1'b1;
                    tentativas_d = '0;
                    state_d      = ST_AGUARDA;
                end
            end
            default: state_d = ST_INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_INICIAL;
            endereco_q   <= '0;
            score_q      <= '0;
            tentativas_q <= '0;
            timer_q      <= '0;
            jogada_reg_q <= '0;
            avanca_q     <= 1'b0;
`ifdef BONUS_RAPIDO_EN
            rapido_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            endereco_q   <= endereco_d;
            score_q      <= score_d;
            tentativas_q <= tentativas_d;
            timer_q      <= timer_d;
            jogada_reg_q <= jogada_reg_d;
            avanca_q     <= avanca_d;
`ifdef BONUS_RAPIDO_EN
            rapido_q     <= rapido_d;
`endif
        end
    end

    assign endereco  = endereco_q;
    assign score     = score_q;
    assign acertou   = (state_q == ST_ACERTOU);
    assign errou     = (state_q == ST_ERROU);
    assign timeout   = (state_q == ST_TIMEOUT);
    assign pronto    = (state_q == ST_FIM) || (state_q == ST_TIMEOUT);
    assign db_estado = state_q;

endmodule

// File: doc/unidade_controle_quiz.md
Name: unidade_controle_quiz

Overview:
Parametrised successor of the prova control unit. It is a Moore FSM with its own question counter, attempt counter, timeout timer and score register. It runs a quiz of N_PERGUNTAS questions with retries, release-wait debouncing and a final score. It sits between the button/ROM datapath (jogada, resposta_certa) and the display/LED logic.

Parameters:
N_PERGUNTAS, 8, number of questions per game (>=2)
NB, 4, width of jogada/resposta buses
TIMEOUT_CICLOS, 5000, cycles allowed in AGUARDA before timeout (>=2)
MAX_TENTATIVAS, 2, attempts per question before forced advance (>=1)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
iniciar  in  1  start/restart level
jogada  in  NB  raw button vector; nonzero = move made
resposta_certa  in  NB  expected answer from ROM at endereco
endereco  out  AW=max(1,$clog2(N_PERGUNTAS))  current question index (ROM address)
score  out  SW=$clog2(2*N_PERGUNTAS+1)  accumulated points
acertou  out  1  one-cycle pulse, correct answer
errou  out  1  one-cycle pulse, wrong answer
timeout  out  1  high while in TIMEOUT
pronto  out  1  high in FIM or TIMEOUT
db_estado  out  4  state code

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset).
- Reset: state=INICIAL. endereco, score, tentativas, timer, jogada_reg and avanca are all 0. All outputs are 0 on the cycle after the reset edge. A reset asserted mid-game aborts the game immediately.
- Outputs are registered-state decodes (Moore); no output depends combinationally on inputs.
- States and db_estado codes:
  - INICIAL=0: iniciar -> PREPARA.
  - PREPARA=1: clears endereco, score, tentativas, timer. Always -> AGUARDA.
  - AGUARDA=5: timer+1 per cycle. jogada!=0 -> REGISTRA; jogada has priority over timeout in the same cycle. Else if timer==TIMEOUT_CICLOS-1 -> TIMEOUT. First-cycle jogada goes to REGISTRA after exactly 1 cycle.
  - REGISTRA=6: jogada_reg<=jogada -> COMPARA.
  - COMPARA=7: jogada_reg==resposta_certa -> ACERTOU, else ERROU. Exact NB-bit equality; multi-button vectors count as wrong unless equal.
  - ACERTOU=8: acertou=1; score+=1, saturating at 2*N_PERGUNTAS; avanca<=1 -> SOLTA.
  - ERROU=9: errou=1; tentativas+1. avanca<=1 if tentativas+1==MAX_TENTATIVAS, else avanca<=0 (retry same endereco) -> SOLTA.
  - SOLTA=C: waits for jogada==0, with no timeout here. Then goes to PROXIMA if avanca, else AGUARDA.
  - PROXIMA=A: if endereco==N_PERGUNTAS-1 -> FIM. Else endereco+1, tentativas<=0 -> AGUARDA.
  - FIM=B: pronto=1; score held; iniciar -> PREPARA.
  - TIMEOUT=D: pronto=1, timeout=1; score/endereco held; iniciar -> PREPARA.
  - Unused codes -> INICIAL.
- The timer is cleared in every state except AGUARDA, so each attempt gets the full TIMEOUT_CICLOS.
- endereco never wraps; the last question always exits to FIM.
- iniciar is ignored outside INICIAL/FIM/TIMEOUT.

Optional Feature:
BONUS_RAPIDO_EN:
- Defined: flag rapido is latched on the AGUARDA->REGISTRA edge as (timer < TIMEOUT_CICLOS/2). ACERTOU adds 2 if rapido, else 1. Saturation is unchanged.
- Undefined: the flag logic is absent and every correct answer adds 1.

Test Plan:
- Params N=4, NB=4, TIMEOUT=8, MAX_T=2, bonus off.
- All correct: iniciar, answer resposta_certa on each question then release. Required: four acertou pulses, endereco 0->3, FIM with pronto=1, score=4.
- Retry: question 0, first answer 4'b0010 vs correct 4'b0001, then 4'b0001. Required: errou pulse, endereco stays 0 after SOLTA, then acertou, score=1, endereco=1.
- Exhausted attempts: question 0, two wrong answers. Required: two errou pulses, endereco advances to 1, score=0.
- Timeout: no jogada for 8 cycles in AGUARDA. Required: TIMEOUT on the 9th cycle, db_estado=D, timeout=pronto=1, score held. Then iniciar -> PREPARA with score=0.
- Simultaneous jogada and timeout at timer==7: required REGISTRA, not TIMEOUT. Reset asserted in COMPARA: required db_estado=0 and all outputs 0 the next cycle.
- BONUS_RAPIDO_EN: correct at timer=1 gives score+2; correct at timer=5 gives score+1.
